// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller family: count sizing,
// default thresholds and the registered status bundle.
package fifo_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH    = 4;
    localparam int unsigned DEFAULT_AEMPTY_THRESH = 2;

    // Occupancy must represent 0..depth inclusive, hence one bit above the pointer.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned default_afull_thresh(input int unsigned addr_width);
        return (1 << addr_width) - 2;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ctrl_ext.sv
// Pointer, occupancy and status controller for a first-word-fall-through FIFO
// wrapped around an external register file (sync write, combinational read).
module fifo_ctrl_ext
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH  = default_afull_thresh(ADDR_WIDTH),
    parameter int unsigned AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic                  clr_err_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   word_count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = count_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $fatal(1, "fifo_ctrl_ext: ADDR_WIDTH must be >= 1");
    end
    if (!(AEMPTY_THRESH >= 1 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
        $fatal(1, "fifo_ctrl_ext: need 1 <= AEMPTY_THRESH < AFULL_THRESH <= depth");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    fifo_status_t          status_q;
    fifo_status_t          status_next;
    logic                  overflow_q;
    logic                  underflow_q;

    logic push_ok;
    logic pop_ok;
    logic overflow_set;
    logic underflow_set;

    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign push_ok       = wr_i & (~status_q.full | rd_i);
    assign pop_ok        = rd_i & ~status_q.empty;
    assign overflow_set  = wr_i & status_q.full & ~rd_i;
    assign underflow_set = rd_i & status_q.empty;

    always_comb begin
        count_next = count_q;
        if (push_ok && !pop_ok) begin
            count_next = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_q - CW'(1);
        end
    end

    // Flags are derived from the next count so they land on the same edge as the count.
    always_comb begin
        status_next.full         = (count_next == DEPTH_C);
        status_next.empty        = (count_next == '0);
        status_next.almost_full  = (count_next >= AFULL_C);
        status_next.almost_empty = (count_next <= AEMPTY_C);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q                  <= '0;
            rd_ptr_q                  <= '0;
            count_q                   <= '0;
            status_q.full             <= 1'b0;
            status_q.empty            <= 1'b1;
            status_q.almost_full      <= 1'b0;
            status_q.almost_empty     <= 1'b1;
            overflow_q                <= 1'b0;
            underflow_q               <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            count_q  <= count_next;
            status_q <= status_next;

            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (clr_err_i) begin
                overflow_q <= 1'b0;
            end

            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (clr_err_i) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign wr_en_o        = push_ok;
    assign wr_addr_o      = wr_ptr_q;
    assign rd_addr_o      = rd_ptr_q;
    assign full_o         = status_q.full;
    assign empty_o        = status_q.empty;
    assign almost_full_o  = status_q.almost_full;
    assign almost_empty_o = status_q.almost_empty;
    assign word_count_o   = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_ext.sv
// Bench for fifo_ctrl_ext at depth 4: directed vector table, async-reset sequence,
// then randomized traffic against a queue-based reference with a local register file.
module tb_fifo_ctrl_ext;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF_TH = 3;
    localparam int unsigned AE_TH = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    wdata = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          full, empty, afull, aempty, ovf, udf;
    logic [AW:0]   count;

    logic [7:0] mem [DEPTH];

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic          pre_wen;
    logic [7:0]    pre_head;
    logic [AW-1:0] pre_wa;

    fifo_ctrl_ext #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (AF_TH),
        .AEMPTY_THRESH(AE_TH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_i          (wr),
        .rd_i          (rd),
        .clr_err_i     (clr),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .rd_addr_o     (rd_addr),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull),
        .almost_empty_o(aempty),
        .word_count_o  (count),
        .overflow_o    (ovf),
        .underflow_o   (udf)
    );

    always #5 clk = ~clk;

    // Stand-in for the register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    // Called at posedge+1: drive, sample the combinational side, cross one edge.
    task automatic apply(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr = w; rd = r; clr = c; wdata = d;
        #1;
        pre_wen  = wr_en;
        pre_head = mem[rd_addr];
        pre_wa   = wr_addr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr, rd, clr;
        logic [7:0]  wdata;
        logic        wen;
        logic        chk_head;
        logic [7:0]  head;
        int unsigned cnt;
        logic [5:0]  flags;   // {empty, full, afull, aempty, ovf, udf}
        int unsigned wa, ra;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic r, logic c, logic [7:0] d, logic wen,
                                logic ch, logic [7:0] hd, int unsigned cnt, logic [5:0] fl,
                                int unsigned wa, int unsigned ra);
        vec_t v;
        v.wr = w; v.rd = r; v.clr = c; v.wdata = d; v.wen = wen;
        v.chk_head = ch; v.head = hd; v.cnt = cnt; v.flags = fl; v.wa = wa; v.ra = ra;
        return v;
    endfunction

    task automatic do_reset();
        wr = 0; rd = 0; clr = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic       m_ovf, m_udf;
        int unsigned pushes, pops;
        logic w, r, c, push_ok, pop_ok;
        logic [7:0] d;
        int unsigned wr_pct, rd_pct;

        //          wr rd clr data  wen chk head  cnt flags      wa ra
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 6'b100100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 6'b100100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 6'b100100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'hA1, 1, 0, 8'h00, 1, 6'b000100, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'hA2, 1, 1, 8'hA1, 2, 6'b000000, 2, 0));
        vecs.push_back(mk(1, 0, 0, 8'hA3, 1, 1, 8'hA1, 3, 6'b001000, 3, 0));
        vecs.push_back(mk(1, 0, 0, 8'hA4, 1, 1, 8'hA1, 4, 6'b011000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'hB0, 0, 1, 8'hA1, 4, 6'b011010, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8'hB1, 1, 1, 8'hA1, 4, 6'b011010, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hA2, 3, 6'b001010, 1, 2));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hA3, 2, 6'b000010, 1, 3));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hA4, 1, 6'b000110, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hB1, 0, 6'b100110, 1, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 6'b100111, 1, 1));
        vecs.push_back(mk(1, 1, 0, 8'hC1, 1, 0, 8'h00, 1, 6'b000111, 2, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 8'hC1, 1, 6'b000100, 2, 1));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hC1, 0, 6'b100100, 2, 2));
        vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 6'b100101, 2, 2));
        vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 6'b100100, 2, 2));

        do_reset();
        check("reset_count", 32'(count), 0);
        check("reset_flags", 32'({empty, full, afull, aempty, ovf, udf}), 32'b100100);

        foreach (vecs[i]) begin
            apply(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wdata);
            check($sformatf("v%0d_wen", i), 32'(pre_wen), 32'(vecs[i].wen));
            if (vecs[i].chk_head) check($sformatf("v%0d_head", i), 32'(pre_head), 32'(vecs[i].head));
            check($sformatf("v%0d_count", i), 32'(count), vecs[i].cnt);
            check($sformatf("v%0d_flags", i), 32'({empty, full, afull, aempty, ovf, udf}), 32'(vecs[i].flags));
            check($sformatf("v%0d_addr", i), 32'({wr_addr, rd_addr}), (vecs[i].wa << AW) | vecs[i].ra);
        end

        // Asynchronous reset at count 3, between clock edges.
        apply(1, 0, 0, 8'hD1);
        apply(1, 0, 0, 8'hD2);
        apply(1, 0, 0, 8'hD3);
        check("pre_rst_count", 32'(count), 3);
        wr = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_flags", 32'({empty, full, afull, aempty, ovf, udf}), 32'b100100);
        check("async_rst_addr", 32'({wr_addr, rd_addr}), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        apply(1, 0, 0, 8'hE1);
        check("post_rst_wa", 32'(pre_wa), 0);
        check("post_rst_wen", 32'(pre_wen), 1);
        check("post_rst_count", 32'(count), 1);
        apply(0, 0, 0, 8'h00);
        check("post_rst_head", 32'(pre_head), 32'h0E1);

        // Randomized traffic against a queue reference.
        do_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; pushes = 0; pops = 0;
        wr_pct = 50; rd_pct = 50;
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) begin
                wr_pct = $urandom_range(90, 10);
                rd_pct = $urandom_range(90, 10);
            end
            w = ($urandom_range(99) < wr_pct);
            r = ($urandom_range(99) < rd_pct);
            c = ($urandom_range(99) < 8);
            d = 8'($urandom);
            push_ok = w && (q.size() < DEPTH || r);
            pop_ok  = r && q.size() > 0;
            apply(w, r, c, d);
            check("rnd_wen", 32'(pre_wen), 32'(push_ok));
            if (q.size() > 0) check("rnd_head", 32'(pre_head), 32'(q[0]));
            if (w && !r && q.size() == DEPTH) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (r && q.size() == 0) m_udf = 1;
            else if (c) m_udf = 0;
            if (pop_ok) begin
                void'(q.pop_front());
                pops++;
            end
            if (push_ok) begin
                q.push_back(d);
                pushes++;
            end
            check("rnd_count", 32'(count), q.size());
            check("rnd_flags", 32'({empty, full, afull, aempty, ovf, udf}),
                  32'({q.size() == 0, q.size() == DEPTH, q.size() >= AF_TH,
                       q.size() <= AE_TH, m_ovf, m_udf}));
            check("rnd_addr", 32'({wr_addr, rd_addr}), ((pushes % DEPTH) << AW) | (pops % DEPTH));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_ext.md
Name: fifo_ctrl_ext

Overview:
Pointer and status controller for a FIFO built around the team's register_file: write port driven by wr_en_o and wr_addr_o, combinational read port driven by rd_addr_o.
- Converts push/pop requests into register-file write enables and read/write addresses.
- Maintains an exact occupancy count, almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- The FIFO is first-word-fall-through: head data is visible on the register-file read port whenever empty_o=0.

Parameters:
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH
AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full_o asserts when count >= this value
AEMPTY_THRESH, 2, almost_empty_o asserts when count <= this value

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous, active-high reset
wr_i  in  1  push request
rd_i  in  1  pop request; head word is consumed at the clock edge
clr_err_i  in  1  clears the sticky error flags
wr_en_o  out  1  register_file write enable (combinational)
wr_addr_o  out  ADDR_WIDTH  register_file write address (the write pointer)
rd_addr_o  out  ADDR_WIDTH  register_file read address (the read pointer)
full_o  out  1  count == depth
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AFULL_THRESH
almost_empty_o  out  1  count <= AEMPTY_THRESH
word_count_o  out  ADDR_WIDTH+1  current occupancy, 0..depth
overflow_o  out  1  sticky: push rejected
underflow_o  out  1  sticky: pop rejected

Behaviour:
- Reset (async assert, sync release):
  - Pointers = 0, count = 0.
  - empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
  - overflow_o=0, underflow_o=0.
- Accept conditions:
  - push_ok = wr_i & (~full | rd_i).
  - pop_ok = rd_i & ~empty.
  - wr_en_o = push_ok. This is the only combinational output.
- Pointer updates:
  - push_ok increments the write pointer at the edge; pop_ok increments the read pointer.
  - Both pointers wrap modulo depth.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both or neither: unchanged.
- Latency:
  - A word written at edge N is readable at rd_addr_o after edge N when the FIFO was empty; empty_o deasserts after the same edge.
  - Flags update on the edge that changes count.
- All status outputs are registered, computed from the next count, and never glitch.
- Full plus simultaneous rd_i & wr_i:
  - Both are accepted and count stays at depth.
  - rd_addr_o == wr_addr_o; the old word is read combinationally before it is overwritten at the edge.
- Empty plus simultaneous rd_i & wr_i:
  - The write is accepted, the pop is rejected, and underflow_o sets.
  - count becomes 1.
- overflow_o sets on wr_i & full & ~rd_i.
- underflow_o sets on rd_i & empty.
- Clearing errors:
  - clr_err_i clears both error flags at the next edge.
  - If an error event and clr_err_i occur in the same cycle, set wins.
- Rejected requests never change pointers, count or register_file contents.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - Register-file contents are not cleared; they are don't-care.
- Width rule: count is ADDR_WIDTH+1 bits so that the value depth is representable.
- Parameter constraints (checked with elaboration-time asserts):
  - 1 <= AEMPTY_THRESH < AFULL_THRESH <= depth.
  - ADDR_WIDTH >= 1.

Decomposition:
- Shared package fifo_pkg holds:
  - the count-width function clog2(depth)+1;
  - default threshold constants;
  - a typedef for the status bundle (full, empty, almost_full, almost_empty).
- No sub-module inside fifo_ctrl_ext.
- A thin top fifo_ext instantiates fifo_ctrl_ext plus register_file. fifo_ext is verified alongside, but this spec governs fifo_ctrl_ext only.

Test Plan:
All scenarios use ADDR_WIDTH=2 (depth 4), AFULL_THRESH=3, AEMPTY_THRESH=1.
1. Release reset, idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, errors=0, both addresses=0.
2. Push 4 words (0xA1..0xA4) on consecutive cycles -> count 1,2,3,4; almost_empty drops after count=2; almost_full rises at count=3; full at 4; wr_addr wraps to 0.
3. While full, push without pop -> wr_en_o=0, overflow_o=1, count stays 4. Then push+pop together -> head 0xA1 is read, new word written at address 0, count stays 4, full stays 1.
4. Pop until empty, reading 0xA2,0xA3,0xA4,new word -> empty=1. A fifth pop sets underflow_o. Push+pop on empty -> count=1, underflow stays 1.
5. Pulse clr_err_i with no error -> both flags clear. Pulse clr_err_i with a simultaneous rd on empty -> underflow_o remains 1 (set wins).
6. Assert rst_i asynchronously mid-burst at count=3 -> outputs return to reset values immediately without waiting for a clock edge. The next push after release lands at address 0.
